// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the requester arbiter (master side) and the slave fabric.
interface apb_master_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  p_sel;
    logic                  p_enable;
    logic                  p_write;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_wdata;
    logic [DATA_WIDTH-1:0] p_rdata;
    logic                  p_ready;

    modport master (
        output p_sel, p_enable, p_write, p_addr, p_wdata,
        input  p_rdata, p_ready
    );

    modport slave (
        input  p_sel, p_enable, p_write, p_addr, p_wdata,
        output p_rdata, p_ready
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving an APB master sequencer
// (IDLE -> SETUP -> ACCESS) with a bounded wait-state timeout.
module apb_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  p_clk,
    input  logic                  p_resetn,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            req_ack,
    output logic [1:0]            req_done,
    output logic                  req_err,
    output logic [DATA_WIDTH-1:0] req_rdata,
    apb_master_arbiter_if.master  apb
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    localparam bit        TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_write;
    logic                  r_last_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [15:0]           r_cnt;
    logic [1:0]            r_done;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_grant;
    logic w_start;
    logic w_complete;
    logic w_abort;

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign w_grant = req_valid[1] & (~req_valid[0] | ~r_last_grant);

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_start = 1'b1;
                    w_next  = SETUP;
                end
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                if (apb.p_ready) begin
                    w_complete = 1'b1;
                    w_next     = IDLE;
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (!p_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge p_clk) begin
        if (!p_resetn) begin
            r_owner      <= 1'b0;
            r_write      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_start) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_write      <= req_write[w_grant];
                r_addr       <= w_grant ? req_addr1 : req_addr0;
                r_wdata      <= w_grant ? req_wdata1 : req_wdata0;
                r_cnt        <= '0;
            end
            if (r_state == ACCESS && !apb.p_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_complete || w_abort) begin
                r_done <= r_owner ? 2'b10 : 2'b01;
                r_err  <= w_abort;
            end
            if (w_complete && !r_write) begin
                r_rdata <= apb.p_rdata;
            end
        end
    end

    assign apb.p_sel    = (r_state == SETUP) || (r_state == ACCESS);
    assign apb.p_enable = (r_state == ACCESS);
    assign apb.p_write  = r_write;
    assign apb.p_addr   = r_addr;
    assign apb.p_wdata  = r_wdata;

    assign req_ack   = (r_state == SETUP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign req_done  = r_done;
    assign req_err   = r_err;
    assign req_rdata = r_rdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Table-driven bench with an ack/done scoreboard for apb_master_arbiter.
module tb_apb_master_arbiter;

    logic        clk;
    logic        p_resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic        req_err;
    logic [31:0] req_rdata;

    apb_master_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_master_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .p_clk     (clk),
        .p_resetn  (p_resetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_wdata0(req_wdata0),
        .req_wdata1(req_wdata1),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .apb       (bus)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        int          waits;
        logic [31:0] rdata;
        int          exp_owner;
        logic        exp_err;
        int          exp_off;
    } vec_t;

    typedef struct {
        logic [1:0]  vec;
        int          cyc;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } ack_t;

    typedef struct {
        logic [1:0]  vec;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } done_t;

    ack_t        ack_q[$];
    done_t       done_q[$];
    ack_t        ea;
    done_t       ed;
    vec_t        tbl[8];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          slv_waits = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic [31:0] m_rdata   = 32'h0;
    logic [31:0] cur_addr  = 32'h0;
    bit          mon_en    = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // APB slave: ready after slv_waits low ACCESS cycles; noise outside ACCESS.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        bus.p_ready = 1'b0;
        bus.p_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.p_sel && bus.p_enable) begin
                bus.p_ready = (acc_cnt == slv_waits);
                bus.p_rdata = slv_rdata;
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                bus.p_ready = 1'($urandom_range(0, 1));
                bus.p_rdata = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (req_ack != 2'b00) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", {30'h0, req_ack}, 32'h0);
                end else begin
                    ea = ack_q.pop_front();
                    chk("ack_vec", {30'h0, req_ack}, {30'h0, ea.vec});
                    chk("ack_cycle", cyc, ea.cyc);
                    chk("setup_sel_en", {30'h0, bus.p_sel, bus.p_enable}, 32'h2);
                    chk("setup_addr", bus.p_addr, ea.addr);
                    chk("setup_write", {31'h0, bus.p_write}, {31'h0, ea.wr});
                    chk("setup_wdata", bus.p_wdata, ea.wdata);
                    cur_addr = ea.addr;
                end
            end
            if (bus.p_sel && bus.p_enable) begin
                chk("access_addr", bus.p_addr, cur_addr);
            end
            if (req_done != 2'b00) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", {30'h0, req_done}, 32'h0);
                end else begin
                    ed = done_q.pop_front();
                    chk("done_vec", {30'h0, req_done}, {30'h0, ed.vec});
                    chk("done_cycle", cyc, ed.cyc);
                    chk("done_err", {31'h0, req_err}, {31'h0, ed.err});
                    chk("done_rdata", req_rdata, ed.rdata);
                    chk("done_bus_idle", {31'h0, bus.p_sel}, 32'h0);
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit push_done);
        ack_t  a;
        done_t d;
        @(posedge clk);
        #1;
        req_valid  = v.valid;
        req_write  = v.write;
        req_addr0  = v.addr0;
        req_addr1  = v.addr1;
        req_wdata0 = v.wdata0;
        req_wdata1 = v.wdata1;
        slv_waits  = v.waits;
        slv_rdata  = v.rdata;
        a.vec   = (v.exp_owner == 1) ? 2'b10 : 2'b01;
        a.cyc   = cyc + 1;
        a.addr  = (v.exp_owner == 1) ? v.addr1 : v.addr0;
        a.wr    = v.write[v.exp_owner];
        a.wdata = (v.exp_owner == 1) ? v.wdata1 : v.wdata0;
        ack_q.push_back(a);
        if (push_done) begin
            if (!a.wr && !v.exp_err) m_rdata = v.rdata;
            d.vec   = a.vec;
            d.cyc   = cyc + v.exp_off;
            d.err   = v.exp_err;
            d.rdata = m_rdata;
            done_q.push_back(d);
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (req_ack != 2'b00) seen++;
        end
        n_cmp++;
        if (seen < n) begin
            n_fail++;
            $display("FAIL ack_wait: got %0d acks expected %0d", seen, n);
        end
    endtask

    task automatic wait_empty(input int budget);
        int t;
        t = 0;
        while ((ack_q.size() != 0 || done_q.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (ack_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_wait: got %0d pending expected 0",
                     ack_q.size() + done_q.size());
            ack_q.delete();
            done_q.delete();
        end
    endtask

    initial begin
        vec_t rv;
        int   cnt;
        int   c0;

        // valid, write, addr0, addr1, wdata0, wdata1, waits, rdata, owner, err, done offset
        tbl[0] = '{2'b01, 2'b01, 32'h10, 32'h0, 32'hA5A5_0001, 32'h0, 0, 32'h0, 0, 1'b0, 3};
        tbl[1] = '{2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 2, 32'hDEAD_BEEF, 1, 1'b0, 5};
        tbl[2] = '{2'b11, 2'b10, 32'h30, 32'h34, 32'h0, 32'h34, 1, 32'h1234_5678, 0, 1'b0, 4};
        tbl[3] = '{2'b11, 2'b10, 32'h40, 32'h44, 32'h0, 32'hCAFE_0003, 0, 32'hFFFF_0000, 1, 1'b0, 3};
        tbl[4] = '{2'b01, 2'b00, 32'h50, 32'h0, 32'h0, 32'h0, 99, 32'hFFFF_FFFF, 0, 1'b1, 6};
        tbl[5] = '{2'b10, 2'b00, 32'h0, 32'h60, 32'h0, 32'h0, 3, 32'h0BAD_F00D, 1, 1'b0, 6};
        tbl[6] = '{2'b11, 2'b01, 32'h70, 32'h74, 32'h5555_AAAA, 32'h0, 99, 32'h0, 0, 1'b1, 6};
        tbl[7] = '{2'b11, 2'b00, 32'h80, 32'h84, 32'h0, 32'h0, 0, 32'h1357_9BDF, 1, 1'b0, 3};

        p_resetn   = 1'b0;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        req_addr0  = 32'h0;
        req_addr1  = 32'h0;
        req_wdata0 = 32'h0;
        req_wdata1 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel",   {31'h0, bus.p_sel},    32'h0);
        chk("rst_en",    {31'h0, bus.p_enable}, 32'h0);
        chk("rst_write", {31'h0, bus.p_write},  32'h0);
        chk("rst_addr",  bus.p_addr,  32'h0);
        chk("rst_wdata", bus.p_wdata, 32'h0);
        chk("rst_ack",   {30'h0, req_ack},  32'h0);
        chk("rst_done",  {30'h0, req_done}, 32'h0);
        chk("rst_err",   {31'h0, req_err},  32'h0);
        chk("rst_rdata", req_rdata, 32'h0);
        @(posedge clk);
        #1;
        p_resetn = 1'b1;
        mon_en   = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i], 1'b1);
            wait_acks(1, 10);
            @(posedge clk);
            #1;
            req_valid = 2'b00;
            wait_empty(60);
        end

        // Contention: last grant was requester 1, so order is 0,1,0,1.
        @(posedge clk);
        #1;
        c0 = cyc;
        slv_waits  = 0;
        req_valid  = 2'b11;
        req_write  = 2'b11;
        req_addr0  = 32'hA0;
        req_addr1  = 32'hB0;
        req_wdata0 = 32'h1111_0000;
        req_wdata1 = 32'h2222_0000;
        for (int k = 0; k < 4; k++) begin
            ea.vec   = k[0] ? 2'b10 : 2'b01;
            ea.cyc   = c0 + 3 * k + 1;
            ea.addr  = k[0] ? 32'hB0 : 32'hA0;
            ea.wr    = 1'b1;
            ea.wdata = k[0] ? 32'h2222_0000 : 32'h1111_0000;
            ack_q.push_back(ea);
            ed.vec   = ea.vec;
            ed.cyc   = c0 + 3 * k + 3;
            ed.err   = 1'b0;
            ed.rdata = m_rdata;
            done_q.push_back(ed);
        end
        wait_acks(4, 20);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_empty(60);

        // Reset in ACCESS after requester 0 won, leaving last grant at 0.
        rv = '{2'b01, 2'b01, 32'h90, 32'h0, 32'h7777_0000, 32'h0, 99, 32'h0, 0, 1'b0, 0};
        issue(rv, 1'b0);
        wait_acks(1, 10);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        p_resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_sel",   {31'h0, bus.p_sel},    32'h0);
        chk("mid_rst_en",    {31'h0, bus.p_enable}, 32'h0);
        chk("mid_rst_done",  {30'h0, req_done},     32'h0);
        chk("mid_rst_rdata", req_rdata, 32'h0);
        m_rdata = 32'h0;
        @(posedge clk);
        #1;
        p_resetn = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_done != 2'b00) cnt++;
        end
        chk("no_done_after_reset", cnt, 32'h0);

        rv = '{2'b11, 2'b00, 32'hC0, 32'hC4, 32'h0, 32'h0, 0, 32'h2468_ACE0, 0, 1'b0, 3};
        issue(rv, 1'b1);
        wait_acks(1, 10);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_empty(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
